// File: rtl/rr_mux8to1.sv
// 8-to-1 round-robin stream multiplexer with a registered, source-tagged output.
// Grant search starts at the channel after the last one granted, so every
// continuously valid channel is served within eight output transfers.
module rr_mux8to1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EN,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic [2:0]       ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [2:0]       out_sel_q, out_sel_d;
  logic [2:0]       grant;
  logic             found;
  logic             load;

  // Rotating priority search: first valid channel at or after ptr, mod 8.
  always_comb begin
    grant = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found && in_valid[ptr_q + 3'(k)]) begin
        grant = ptr_q + 3'(k);
        found = 1'b1;
      end
    end
  end

  // Accept a new word when enabled, something is valid and the output slot
  // is free or draining this cycle; nothing is accepted while in reset.
  always_comb begin
    load     = EN & found & (~out_valid_q | out_ready) & ~rst;
    in_ready = load ? (8'b1 << grant) : 8'b0;
  end

  // Next state: load overrides drain so a drain and load share one cycle.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant*WIDTH +: WIDTH];
      out_sel_d   = grant;
      ptr_d       = grant + 3'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 3'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
